// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: requester handshakes plus MAR/memory strobes of the data-memory address path
interface dmem_access_ctrl_if #(parameter int ADDR_W = 24);
  logic              cpu_req, cpu_we, cpu_done;
  logic              ext_req, ext_we, ext_done;
  logic [ADDR_W-1:0] cpu_addr, ext_addr, mar_addr;
  logic              mar_load, mem_we, mdr_load, grant_ext, busy;
  modport master (
    output cpu_req, cpu_we, cpu_addr, ext_req, ext_we, ext_addr,
    input  cpu_done, ext_done, mar_load, mar_addr, mem_we, mdr_load, grant_ext, busy
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, ext_req, ext_we, ext_addr,
    output cpu_done, ext_done, mar_load, mar_addr, mem_we, mdr_load, grant_ext, busy
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: round-robin CPU/loader arbiter sequencing MAR load, memory latency and transfer strobes
module dmem_access_ctrl #(
  parameter int ADDR_W  = 24,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input logic clk,
  input logic reset,
  dmem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, XFER} state_t;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q, last_ext, pick_ext;
  logic [ADDR_W-1:0] pick_addr;
  // loader wins only when alone or when the CPU had the last grant
  assign pick_ext  = bus.ext_req && (!bus.cpu_req || !last_ext);
  assign pick_addr = pick_ext ? bus.ext_addr : bus.cpu_addr;
  always_ff @(posedge clk) begin
    bus.mar_load <= 1'b0;
    bus.mem_we   <= 1'b0;
    bus.mdr_load <= 1'b0;
    bus.cpu_done <= 1'b0;
    bus.ext_done <= 1'b0;
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      last_ext      <= 1'b1;
      bus.mar_addr  <= '0;
      bus.grant_ext <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cpu_req || bus.ext_req) begin
          state         <= ADDR;
          bus.mar_load  <= 1'b1;
          bus.busy      <= 1'b1;
          bus.grant_ext <= pick_ext;
          last_ext      <= pick_ext;
          bus.mar_addr  <= pick_addr;
          we_q          <= pick_ext ? bus.ext_we : bus.cpu_we;
        end
        ADDR: begin
          cnt   <= CNT_W'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          state        <= XFER;
          bus.mem_we   <= we_q;
          bus.mdr_load <= !we_q;
          bus.cpu_done <= !bus.grant_ext;
          bus.ext_done <= bus.grant_ext;
        end else cnt <= cnt - 1'b1;
        XFER: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.grant_ext <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: vector table, hand sequences and random traffic against a transaction-level model
module tb_dmem_access_ctrl;
  localparam int L = 2;
  logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
  always #5 clk = ~clk;
  dmem_access_ctrl_if #(.ADDR_W(24)) b1 ();
  dmem_access_ctrl_if #(.ADDR_W(24)) b2 ();
  dmem_access_ctrl #(.ADDR_W(24), .MEM_LAT(L), .CNT_W(4)) dut (.clk(clk), .reset(rst), .bus(b1));
  dmem_access_ctrl #(.ADDR_W(24), .MEM_LAT(1), .CNT_W(4)) dut1 (.clk(clk), .reset(rst2), .bus(b2));
  typedef struct {
    bit rst, cr, cw;
    logic [23:0] ca;
    bit er, ew;
    logic [23:0] ea;
    logic [30:0] exp;
  } vec_t;
  vec_t tbl[$];
  int errs = 0, checks = 0;
  // transaction model: k counts cycles since the grant, done lands at k == L+2
  bit m_act = 0, m_own = 0, m_we = 0, m_last_ext = 1;
  int m_k = 0;
  logic [23:0] m_mar = '0;
  function automatic logic [30:0] obs();
    return {b1.busy, b1.mar_load, b1.mem_we, b1.mdr_load, b1.cpu_done, b1.ext_done, b1.grant_ext, b1.mar_addr};
  endfunction
  function automatic logic [30:0] model_out();
    bit x;
    x = m_act && m_k == L + 2;
    return {m_act, m_act && m_k == 1, x && m_we, x && !m_we, x && !m_own, x && m_own, m_act && m_own, m_mar};
  endfunction
  task automatic chk(input string n, input logic [30:0] a, input logic [30:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_act = 0; m_mar = '0; m_last_ext = 1;
    end else if (!m_act) begin
      if (b1.cpu_req || b1.ext_req) begin
        m_own = b1.ext_req && !(b1.cpu_req && m_last_ext);
        m_last_ext = m_own;
        m_act = 1;
        m_k = 1;
        m_mar = m_own ? b1.ext_addr : b1.cpu_addr;
        m_we = m_own ? b1.ext_we : b1.cpu_we;
      end
    end else if (m_k == L + 2) m_act = 0;
    else m_k++;
    #1;
  endtask
  task automatic drive(input bit r, cr, cw, input logic [23:0] ca, input bit er, ew, input logic [23:0] ea);
    rst = r; b1.cpu_req = cr; b1.cpu_we = cw; b1.cpu_addr = ca;
    b1.ext_req = er; b1.ext_we = ew; b1.ext_addr = ea;
  endtask
  function automatic void add(input bit r, cr, cw, input logic [23:0] ca, input bit er, ew,
                              input logic [23:0] ea, input logic [6:0] f, input logic [23:0] a);
    vec_t v;
    v = '{r, cr, cw, ca, er, ew, ea, {f, a}};
    tbl.push_back(v);
  endfunction
  initial begin
    int done_c, nwe, nbad;
    drive(1, 0, 0, '0, 0, 0, '0);
    b2.cpu_req = 0; b2.cpu_we = 0; b2.cpu_addr = '0;
    b2.ext_req = 0; b2.ext_we = 0; b2.ext_addr = '0;
    // flags: busy mar_load mem_we mdr_load cpu_done ext_done grant_ext
    add(1, 0, 0, 24'h0,      0, 0, 24'h0,      7'b0000000, 24'h000000);
    add(0, 1, 0, 24'h001234, 0, 0, 24'h0,      7'b1100000, 24'h001234);
    add(0, 1, 0, 24'h001234, 0, 0, 24'h0,      7'b1000000, 24'h001234);
    add(0, 1, 0, 24'h001234, 0, 0, 24'h0,      7'b1000000, 24'h001234);
    add(0, 1, 0, 24'h001234, 0, 0, 24'h0,      7'b1001100, 24'h001234);
    add(0, 0, 0, 24'h001234, 0, 0, 24'h0,      7'b0000000, 24'h001234);
    add(0, 0, 0, 24'h0,      1, 1, 24'hABCDEF, 7'b1100001, 24'hABCDEF);
    add(0, 0, 0, 24'h0,      1, 1, 24'hABCDEF, 7'b1000001, 24'hABCDEF);
    add(0, 0, 0, 24'h0,      1, 1, 24'hABCDEF, 7'b1000001, 24'hABCDEF);
    add(0, 0, 0, 24'h0,      1, 1, 24'hABCDEF, 7'b1010011, 24'hABCDEF);
    add(0, 0, 0, 24'h0,      0, 1, 24'hABCDEF, 7'b0000000, 24'hABCDEF);
    add(0, 1, 0, 24'h000055, 0, 0, 24'h0,      7'b1100000, 24'h000055);
    add(0, 0, 1, 24'hFFFFFF, 0, 0, 24'h0,      7'b1000000, 24'h000055);
    add(0, 0, 1, 24'hFFFFFF, 0, 0, 24'h0,      7'b1000000, 24'h000055);
    add(0, 0, 1, 24'hFFFFFF, 0, 0, 24'h0,      7'b1001100, 24'h000055);
    add(0, 0, 1, 24'hFFFFFF, 0, 0, 24'h0,      7'b0000000, 24'h000055);
    add(0, 1, 0, 24'h000077, 0, 0, 24'h0,      7'b1100000, 24'h000077);
    add(0, 1, 0, 24'h000077, 0, 0, 24'h0,      7'b1000000, 24'h000077);
    add(1, 0, 0, 24'h000077, 0, 0, 24'h0,      7'b0000000, 24'h000000);
    add(0, 0, 0, 24'h000077, 0, 0, 24'h0,      7'b0000000, 24'h000000);
    add(0, 0, 0, 24'h000077, 0, 0, 24'h0,      7'b0000000, 24'h000000);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].er, tbl[i].ew, tbl[i].ea);
      step();
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end
    drive(1, 0, 0, '0, 0, 0, '0);
    step();
    drive(0, 1, 0, 24'h000100, 1, 1, 24'h000200);
    for (int c = 1; c <= 20; c++) begin
      step();
      chk($sformatf("collide%0d", c), 31'({b1.cpu_done, b1.ext_done}),
          31'({c % 10 == 4, c % 10 == 9}));
    end
    drive(1, 0, 0, '0, 0, 0, '0);
    step();
    for (int c = 0; c < 400; c++) begin
      drive($urandom % 60 == 0, $urandom % 3 != 0, $urandom % 2 == 1, 24'($urandom),
            $urandom % 3 != 0, $urandom % 2 == 1, 24'($urandom));
      step();
      chk("random", obs(), model_out());
    end
    rst2 = 1;
    step();
    rst2 = 0; b2.cpu_req = 1; b2.cpu_we = 1; b2.cpu_addr = 24'h000042;
    done_c = 0; nwe = 0; nbad = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (b2.cpu_done && done_c == 0) done_c = c;
      if (b2.mem_we) nwe++;
      if (b2.ext_done || b2.mdr_load) nbad++;
      if (b2.cpu_done) b2.cpu_req = 0;
    end
    chk("lat1_done_cycle", 31'(done_c), 31'(3));
    chk("lat1_we_pulses", 31'(nwe), 31'(1));
    chk("lat1_stray", 31'(nbad), 31'(0));
    chk("lat1_mar", 31'(b2.mar_addr), 31'(24'h000042));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
